// File: rtl/hsi_pkg.sv
// Shared definitions for the HSI vector core host side: operation codes,
// status/error codes, the driver state encoding and the job config check.
package hsi_pkg;

    localparam logic [3:0] OP_CROSS = 4'd1;
    localparam logic [3:0] OP_DOT   = 4'd2;

    localparam logic [3:0] ERR_NONE              = 4'h0;
    localparam logic [3:0] ERR_OP                = 4'h1;
    localparam logic [3:0] ERR_INPUT_FIFO_EMPTY  = 4'h2;
    localparam logic [3:0] ERR_OUTPUT_FIFO_FULL  = 4'h3;
    localparam logic [3:0] ERR_BANDS             = 4'h4;
    localparam logic [3:0] ERR_TIMEOUT           = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_FAULT
    } drv_state_e;

    // Out-of-range band counts report BANDS; a legal band count that the
    // operation cannot use (CROSS without exactly 3 bands) reports OP.
    function automatic logic [3:0] check_config(
        input logic [3:0]  op,
        input logic [31:0] bands,
        input int unsigned max_bands
    );
        logic [3:0] code;
        code = ERR_NONE;
        if ((op != OP_CROSS) && (op != OP_DOT)) begin
            code = ERR_OP;
        end else if ((bands == 32'd0) || (bands > max_bands)) begin
            code = ERR_BANDS;
        end else if ((op == OP_CROSS) && (bands != 32'd3)) begin
            code = ERR_OP;
        end
        return code;
    endfunction

endpackage

// File: rtl/hsi_skid_buffer.sv
// Two-entry valid/ready register slice. Output is fully registered and the
// slice sustains one transfer per cycle. The producer tracks free space via
// `count` and never offers data when both entries are occupied.
module hsi_skid_buffer #(
    parameter int unsigned WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             main_free;

    assign main_free = !main_valid_q || out_ready;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign count     = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    // Next-entry selection: refill the output stage from skid first, else from input.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (main_free) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = in_valid;
                if (in_valid) begin
                    skid_data_d = in_data;
                end
            end else begin
                main_valid_d = in_valid;
                if (in_valid) begin
                    main_data_d = in_data;
                end
            end
        end else if (in_valid && !skid_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    // Entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/hsi_core_driver.sv
// Host-side sequencer for the HSI vector core: feeds operand pairs into the
// core input FIFOs, issues start pulses, drains results through a skid
// buffer and reports job completion/fault.
// Optional watchdog: define HSI_DRIVER_TIMEOUT_EN to enable TIMEOUT_CYCLES.
module hsi_core_driver
    import hsi_pkg::*;
#(
    parameter int unsigned COMPONENT_WIDTH = 16,
    parameter int unsigned COMPONENTS_MAX  = 3,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [3:0]                              cfg_op_code,
    input  logic [31:0]                             cfg_num_bands,
    input  logic [15:0]                             cfg_num_pixels,
    input  logic                                    go,
    output logic                                    busy,
    output logic                                    done,
    output logic [3:0]                              status,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    input  logic [COMPONENT_WIDTH*COMPONENTS_MAX-1:0] s_data1,
    input  logic [COMPONENT_WIDTH*COMPONENTS_MAX-1:0] s_data2,
    output logic                                    in1_wr_en,
    output logic                                    in2_wr_en,
    output logic [COMPONENT_WIDTH*COMPONENTS_MAX-1:0] in1_data_in,
    output logic [COMPONENT_WIDTH*COMPONENTS_MAX-1:0] in2_data_in,
    input  logic                                    in1_full,
    input  logic                                    in2_full,
    output logic                                    start,
    output logic [3:0]                              op_code,
    output logic [31:0]                             num_bands,
    output logic                                    out_rd_en,
    input  logic                                    out_empty,
    input  logic [COMPONENT_WIDTH*COMPONENTS_MAX-1:0] out_data_out,
    input  logic [3:0]                              error_code,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic [COMPONENT_WIDTH*COMPONENTS_MAX-1:0] m_data
);

    localparam int unsigned W = COMPONENT_WIDTH * COMPONENTS_MAX;
    localparam logic [15:0] OUTSTANDING_MAX = 16'(FIFO_DEPTH - 1);
    localparam logic [W-1:0] LANE0_MASK = W'({COMPONENT_WIDTH{1'b1}});

    drv_state_e  state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  status_q, status_d;
    logic        start_q, start_d;
    logic [3:0]  op_code_q, op_code_d;
    logic [31:0] num_bands_q, num_bands_d;
    logic [15:0] num_pixels_q, num_pixels_d;
    logic [15:0] pushed_q, pushed_d;
    logic [15:0] drained_q, drained_d;
    logic        in_flight_q;

    logic        run_active;
    logic        drain_active;
    logic [15:0] outstanding;
    logic        push;
    logic        m_fire;
    logic [3:0]  cfg_err;
    logic        enter_run;
    logic        timeout_hit;
    logic [1:0]  sb_count;
    logic [2:0]  slots_used;
    logic        credit_ok;
    logic [W-1:0] sb_in_data;

    assign run_active   = (state_q == ST_RUN);
    assign drain_active = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign outstanding  = pushed_q - drained_q;
    assign cfg_err      = check_config(cfg_op_code, cfg_num_bands, COMPONENTS_MAX);
    assign enter_run    = (state_q == ST_IDLE) && go && (cfg_err == ERR_NONE) &&
                          (cfg_num_pixels != 16'd0);

    // Push side: both core FIFOs are written in the handshake cycle.
    assign s_ready     = run_active && !in1_full && !in2_full &&
                         (pushed_q < num_pixels_q) && (outstanding < OUTSTANDING_MAX);
    assign push        = s_valid && s_ready;
    assign in1_wr_en   = push;
    assign in2_wr_en   = push;
    assign in1_data_in = s_data1;
    assign in2_data_in = s_data2;

    // Drain side: a read is issued only if the skid buffer can take it one
    // cycle later, counting the read already in flight and this cycle's pop.
    assign m_fire     = m_valid && m_ready;
    assign slots_used = 3'(sb_count) + 3'(in_flight_q);
    assign credit_ok  = slots_used <= (3'd1 + 3'(m_fire));
    assign out_rd_en  = drain_active && !out_empty && credit_ok;
    assign sb_in_data = (op_code_q == OP_DOT) ? (out_data_out & LANE0_MASK) : out_data_out;

    hsi_skid_buffer #(
        .WIDTH(W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_flight_q),
        .in_data  (sb_in_data),
        .out_valid(m_valid),
        .out_ready(m_ready),
        .out_data (m_data),
        .count    (sb_count)
    );

`ifdef HSI_DRIVER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;

    // Watchdog: counts active cycles since the last output FIFO read.
    always_comb begin
        timer_d = timer_q;
        if (enter_run || out_rd_en) begin
            timer_d = '0;
        end else if (drain_active) begin
            timer_d = timer_q + TW'(1);
        end
    end

    assign timeout_hit = drain_active && !out_rd_en && (timer_q == TIMEOUT_LAST);

    // Watchdog register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Job sequencing: config latch, counters, state and registered outputs.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        status_d     = status_q;
        op_code_d    = op_code_q;
        num_bands_d  = num_bands_q;
        num_pixels_d = num_pixels_q;
        pushed_d     = pushed_q + 16'(push);
        drained_d    = drained_q + 16'(m_fire);
        start_d      = push;
        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (go) begin
                    op_code_d    = cfg_op_code;
                    num_bands_d  = cfg_num_bands;
                    num_pixels_d = cfg_num_pixels;
                    pushed_d     = '0;
                    drained_d    = '0;
                    status_d     = cfg_err;
                    if (enter_run) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (error_code != ERR_NONE) begin
                    state_d  = ST_FAULT;
                    status_d = error_code;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d  = ST_FAULT;
                    status_d = ERR_TIMEOUT;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end else if (state_q == ST_RUN) begin
                    if (pushed_d == num_pixels_q) begin
                        state_d = ST_DRAIN;
                    end
                end else if (drained_d == num_pixels_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            status_q     <= ERR_NONE;
            start_q      <= 1'b0;
            op_code_q    <= '0;
            num_bands_q  <= '0;
            num_pixels_q <= '0;
            pushed_q     <= '0;
            drained_q    <= '0;
            in_flight_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            status_q     <= status_d;
            start_q      <= start_d;
            op_code_q    <= op_code_d;
            num_bands_q  <= num_bands_d;
            num_pixels_q <= num_pixels_d;
            pushed_q     <= pushed_d;
            drained_q    <= drained_d;
            in_flight_q  <= out_rd_en;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign status    = status_q;
    assign start     = start_q;
    assign op_code   = op_code_q;
    assign num_bands = num_bands_q;

endmodule

// File: tb/tb_hsi_core_driver.sv
// Directed bench for hsi_core_driver with a behavioural HSI core attached.
module tb_hsi_core_driver;
    import hsi_pkg::*;

    localparam int unsigned CW    = 16;
    localparam int unsigned CM    = 3;
    localparam int unsigned W     = CW * CM;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TO    = 64;
`ifdef HSI_DRIVER_TIMEOUT_EN
    localparam int BP_HOLD = 50;
`else
    localparam int BP_HOLD = 100;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   cfg_op_code;
    logic [31:0]  cfg_num_bands;
    logic [15:0]  cfg_num_pixels;
    logic         go;
    logic         busy, done;
    logic [3:0]   status;
    logic         s_valid, s_ready;
    logic [W-1:0] s_data1, s_data2;
    logic         in1_wr_en, in2_wr_en;
    logic [W-1:0] in1_data_in, in2_data_in;
    logic         in1_full, in2_full;
    logic         start;
    logic [3:0]   op_code;
    logic [31:0]  num_bands;
    logic         out_rd_en, out_empty;
    logic [W-1:0] out_data_out;
    logic [3:0]   error_code;
    logic         m_valid, m_ready;
    logic [W-1:0] m_data;

    always #5 clk = ~clk;

    hsi_core_driver #(
        .COMPONENT_WIDTH(CW),
        .COMPONENTS_MAX (CM),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_op_code(cfg_op_code), .cfg_num_bands(cfg_num_bands), .cfg_num_pixels(cfg_num_pixels),
        .go(go), .busy(busy), .done(done), .status(status),
        .s_valid(s_valid), .s_ready(s_ready), .s_data1(s_data1), .s_data2(s_data2),
        .in1_wr_en(in1_wr_en), .in2_wr_en(in2_wr_en),
        .in1_data_in(in1_data_in), .in2_data_in(in2_data_in),
        .in1_full(in1_full), .in2_full(in2_full),
        .start(start), .op_code(op_code), .num_bands(num_bands),
        .out_rd_en(out_rd_en), .out_empty(out_empty), .out_data_out(out_data_out),
        .error_code(error_code),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] vec(input logic [15:0] x0, input logic [15:0] x1,
                                         input logic [15:0] x2);
        return {x2, x1, x0};
    endfunction

    // ---------------- behavioural core ----------------
    logic [W-1:0] in1_fifo[$], in2_fifo[$], out_fifo[$];
    logic [W-1:0] ma, mb;
    logic [3:0]   core_err;
    bit           force_err  = 1'b0;
    bit           hold_empty = 1'b0;
    int           model_viol = 0;

    assign error_code = force_err ? ERR_OUTPUT_FIFO_FULL : core_err;

    function automatic logic [W-1:0] core_compute(input logic [3:0] op, input logic [31:0] nb,
                                                  input logic [W-1:0] a, input logic [W-1:0] b);
        logic [15:0] a0, a1, a2, b0, b1, b2, r0, r1, r2, acc;
        a0 = a[15:0]; a1 = a[31:16]; a2 = a[47:32];
        b0 = b[15:0]; b1 = b[31:16]; b2 = b[47:32];
        if (op == OP_CROSS) begin
            r0 = a1 * b2 - a2 * b1;
            r1 = a2 * b0 - a0 * b2;
            r2 = a0 * b1 - a1 * b0;
            return {r2, r1, r0};
        end
        acc = a0 * b0;
        if (nb > 1) acc = acc + a1 * b1;
        if (nb > 2) acc = acc + a2 * b2;
        return {16'hDEAD, 16'hBEEF, acc};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in1_fifo.delete(); in2_fifo.delete(); out_fifo.delete();
            core_err     <= ERR_NONE;
            out_data_out <= '0;
            in1_full     <= 1'b0;
            in2_full     <= 1'b0;
            out_empty    <= 1'b1;
        end else begin
            if (in1_wr_en) begin
                if (in1_fifo.size() >= DEPTH) model_viol++;
                in1_fifo.push_back(in1_data_in);
            end
            if (in2_wr_en) begin
                if (in2_fifo.size() >= DEPTH) model_viol++;
                in2_fifo.push_back(in2_data_in);
            end
            if (out_rd_en) begin
                if (out_fifo.size() > 0) out_data_out <= out_fifo.pop_front();
                else model_viol++;
            end
            if (start) begin
                if (in1_fifo.size() == 0 || in2_fifo.size() == 0) begin
                    core_err <= ERR_INPUT_FIFO_EMPTY;
                end else begin
                    ma = in1_fifo.pop_front();
                    mb = in2_fifo.pop_front();
                    if (out_fifo.size() >= DEPTH) core_err <= ERR_OUTPUT_FIFO_FULL;
                    else out_fifo.push_back(core_compute(op_code, num_bands, ma, mb));
                end
            end
            in1_full  <= (in1_fifo.size() >= DEPTH);
            in2_full  <= (in2_fifo.size() >= DEPTH);
            out_empty <= hold_empty || (out_fifo.size() == 0);
        end
    end

    // ---------------- source / sink ----------------
    logic [W-1:0] src1_q[$], src2_q[$];
    logic [W-1:0] rx[$];
    bit           sink_ready = 1'b0;
    int           wr_count   = 0;
    bit           hold_pending = 1'b0;
    logic [W-1:0] held_data;

    assign m_ready = sink_ready;

    initial begin
        s_valid = 1'b0;
        s_data1 = '0;
        s_data2 = '0;
        forever begin
            @(posedge clk); #1;
            s_valid = (src1_q.size() > 0);
            if (s_valid) begin
                s_data1 = src1_q[0];
                s_data2 = src2_q[0];
            end
            @(negedge clk);
            if (s_valid && s_ready) begin
                void'(src1_q.pop_front());
                void'(src2_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (in1_wr_en) wr_count++;
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) check("m_hold", {15'd0, m_valid, m_data}, {15'd0, 1'b1, held_data});
            if (m_valid && m_ready) rx.push_back(m_data);
            hold_pending = m_valid && !m_ready;
            held_data    = m_data;
        end
    end

    // ---------------- test sequence ----------------
    task automatic launch(input logic [3:0] op, input logic [31:0] nb, input logic [15:0] n);
        @(posedge clk); #1;
        cfg_op_code    = op;
        cfg_num_bands  = nb;
        cfg_num_pixels = n;
        go             = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        src1_q.push_back(a);
        src2_q.push_back(b);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        src1_q.delete(); src2_q.delete(); rx.delete();
        force_err  = 1'b0;
        hold_empty = 1'b0;
        sink_ready = 1'b0;
        @(negedge clk);
        check("rst_status", status, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int  c;
        bit  seen;
        int  wr0;
        rst_n = 1'b0;
        go = 1'b0;
        cfg_op_code = '0; cfg_num_bands = '0; cfg_num_pixels = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_status", status, 4'h0);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_start", start, 1'b0);
        check("rst_wr_en", in1_wr_en, 1'b0);
        check("rst_rd_en", out_rd_en, 1'b0);
        check("rst_op_code", op_code, 4'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // CROSS happy path
        push_pair(vec(1, 2, 3), vec(4, 5, 6));
        push_pair(vec(1, 0, 0), vec(0, 1, 0));
        sink_ready = 1'b1;
        launch(OP_CROSS, 3, 2);
        @(negedge clk);
        check("cross_busy", busy, 1'b1);
        check("cross_op_code", op_code, 4'd1);
        check("cross_num_bands", num_bands, 32'd3);
        wait_done(100, c, seen);
        check("cross_done", seen, 1'b1);
        check("cross_busy_at_done", busy, 1'b0);
        check("cross_status", status, 4'h0);
        check("cross_count", rx.size(), 2);
        check("cross_r0", rx[0], 48'hFFFD_0006_FFFD);
        check("cross_r1", rx[1], 48'h0001_0000_0000);
        @(negedge clk);
        check("cross_done_pulse", done, 1'b0);

        // DOT happy path
        rx.delete();
        push_pair(vec(1, 2, 3), vec(4, 5, 6));
        launch(OP_DOT, 3, 1);
        wait_done(100, c, seen);
        check("dot_done", seen, 1'b1);
        check("dot_status", status, 4'h0);
        check("dot_count", rx.size(), 1);
        check("dot_r0", rx[0], 48'h0000_0000_0020);

        // Configuration errors and zero-length job
        wr0 = wr_count;
        push_pair(vec(9, 9, 9), vec(9, 9, 9));
        launch(OP_CROSS, 2, 1);
        wait_done(2, c, seen);
        check("cfg_cross2_done", seen, 1'b1);
        check("cfg_cross2_status", status, 4'h1);
        launch(OP_DOT, 5, 1);
        wait_done(2, c, seen);
        check("cfg_bands5_done", seen, 1'b1);
        check("cfg_bands5_status", status, 4'h4);
        launch(4'd7, 3, 1);
        wait_done(2, c, seen);
        check("cfg_badop_status", status, 4'h1);
        launch(OP_DOT, 3, 0);
        wait_done(2, c, seen);
        check("cfg_zero_done", seen, 1'b1);
        check("cfg_zero_status", status, 4'h0);
        check("cfg_no_writes", wr_count - wr0, 0);
        @(posedge clk); #1;
        src1_q.delete(); src2_q.delete();

        // Backpressure: 20 DOT results with the sink stalled
        rx.delete();
        sink_ready = 1'b0;
        for (int k = 0; k < 20; k++) push_pair(vec(16'(k + 1), 0, 0), vec(2, 0, 0));
        repeat (2) @(posedge clk);
        wr0 = wr_count;
        launch(OP_DOT, 1, 20);
        repeat (BP_HOLD) @(negedge clk);
        check("bp_pushes_stalled", wr_count - wr0, 15);
        check("bp_s_ready", s_ready, 1'b0);
        check("bp_error_code", error_code, 4'h0);
        check("bp_busy", busy, 1'b1);
        @(posedge clk); #1;
        sink_ready = 1'b1;
        wait_done(300, c, seen);
        check("bp_done", seen, 1'b1);
        check("bp_status", status, 4'h0);
        check("bp_count", rx.size(), 20);
        for (int k = 0; k < 20; k++) check("bp_result", rx[k], vec(16'(2 * (k + 1)), 0, 0));

        // Injected core fault
        rx.delete();
        sink_ready = 1'b0;
        for (int k = 0; k < 6; k++) push_pair(vec(1, 1, 1), vec(1, 1, 1));
        launch(OP_DOT, 3, 8);
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        force_err = 1'b1;
        wait_done(10, c, seen);
        check("fault_done", seen, 1'b1);
        check("fault_status", status, 4'h3);
        check("fault_busy", busy, 1'b0);
        @(posedge clk); #1;
        force_err = 1'b0;
        push_pair(vec(1, 1, 1), vec(1, 1, 1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("fault_s_ready", s_ready, 1'b0);
            check("fault_rd_en", out_rd_en, 1'b0);
        end
        launch(OP_DOT, 3, 1);
        wait_done(5, c, seen);
        check("fault_go_ignored", seen, 1'b0);
        check("fault_status_sticky", status, 4'h3);
        check("fault_busy_after_go", busy, 1'b0);
        do_reset();

`ifdef HSI_DRIVER_TIMEOUT_EN
        // Watchdog: output FIFO never reports data
        hold_empty = 1'b1;
        sink_ready = 1'b1;
        push_pair(vec(3, 0, 0), vec(3, 0, 0));
        launch(OP_DOT, 1, 1);
        wait_done(100, c, seen);
        check("to_done", seen, 1'b1);
        check("to_status", status, 4'hF);
        check("to_window", (c >= 63 && c <= 67), 1'b1);
        do_reset();
`endif

        check("model_violations", model_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/hsi_core_driver.md
# hsi_core_driver

Host-side sequencer for the HSI vector core. It streams pixel-vector pairs from an upstream valid/ready source into the core's two input FIFOs and issues the core's `start` pulses. It drains the core's output FIFO into a downstream valid/ready sink, then reports completion or fault for a job of `cfg_num_pixels` pixels. It sits between the DMA/stream fabric and the core and is the only agent driving the core's write side and read side.

## Interface
Parameters:
- COMPONENT_WIDTH, 16, bits per band component
- COMPONENTS_MAX, 3, max bands per vector; W = COMPONENT_WIDTH*COMPONENTS_MAX
- FIFO_DEPTH, 16, depth of the core FIFOs; bounds outstanding pixels
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with HSI_DRIVER_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_op_code  in  4  1 = CROSS, 2 = DOT; sampled at `go`
- cfg_num_bands  in  32  bands; sampled at `go`
- cfg_num_pixels  in  16  job length; sampled at `go`
- go  in  1  job start, one-cycle pulse
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end (success or fault)
- status  out  4  0 OK, 1 OP, 4 BANDS, 2/3 core codes, F TIMEOUT; sticky until next accepted `go`
- s_valid / s_ready  in / out  1  upstream handshake
- s_data1, s_data2  in  W  operand vectors
- in1_wr_en, in2_wr_en  out  1  core input FIFO writes
- in1_data_in, in2_data_in  out  W  core input data
- in1_full, in2_full  in  1  core input FIFO full
- start  out  1  core start pulse
- op_code  out  4  latched operation code
- num_bands  out  32  latched band count
- out_rd_en  out  1  core output FIFO read
- out_empty  in  1  core output FIFO empty
- out_data_out  in  W  core output data, valid the cycle after `out_rd_en`
- error_code  in  4  core error
- m_valid / m_ready  out / in  1  downstream handshake
- m_data  out  W  result

## Operation
- FSM: IDLE, RUN, DRAIN, DONE, FAULT.
- **IDLE**
  - `go` latches the configuration.
  - Invalid config: CROSS requires bands = 3; DOT requires 1..COMPONENTS_MAX; any other op_code gives status 1. A band error gives status 4. Either case goes to DONE with no traffic.
  - cfg_num_pixels = 0 goes to DONE with status 0.
  - Otherwise go to RUN.
- **RUN**
  - s_ready = !in1_full && !in2_full && pushed < N && outstanding < FIFO_DEPTH-1, where outstanding = pushed − drained.
  - A handshake writes both FIFOs in the same cycle, combinationally: wr_en = s_valid && s_ready, with data passed through.
  - `start` is registered and pulses exactly one cycle after each push. This guarantees a non-empty input FIFO when the core sees it.
  - The outstanding bound keeps the core's output FIFO from ever filling.
  - Go to DRAIN when pushed == N.
- **Drain path (RUN and DRAIN)**
  - out_rd_en = !out_empty && skid-buffer credit, counting one read in flight.
  - Read data enters a 2-entry skid buffer feeding m_*.
  - For DOT, m_data is lane 0 with upper lanes zeroed. For CROSS, all three lanes pass through.
  - drained increments on each m handshake.
- **DRAIN → DONE** when drained == N. DONE pulses `done` and returns to IDLE.
- **Faults**
  - Any nonzero error_code in RUN or DRAIN latches status = error_code, goes to FAULT and pulses done.
  - FAULT forces s_ready = 0 and out_rd_en = 0 and ignores `go`. Only reset exits FAULT; the core shares that reset.
- `go` while busy is ignored.
- Counters are 16 bits and never wrap, since they are bounded by N.

## Timing
- Reset values: all outputs 0; status 0; FSM in IDLE; skid buffer empty.
- busy is high from the cycle after an accepted `go` until the DONE cycle; done and busy=0 fall in the same cycle.
- Push side: 0-cycle accept-to-write; `start` is +1 cycle.
- Drain side: out_empty low → m_valid after 2 cycles (read, then skid load).
- Skid buffer: full throughput, 1 result per cycle.
- m_data is held stable while m_valid && !m_ready.
- Simultaneous push and drain in the same cycle: outstanding is unchanged.
- An error_code arriving in the same cycle as the final drain still faults.
- Reset mid-job: immediate return to IDLE, counters cleared.

## Configuration
- HSI_DRIVER_TIMEOUT_EN defined:
  - A counter clears on each out_rd_en and on entry to RUN, and increments in RUN/DRAIN otherwise.
  - Reaching TIMEOUT_CYCLES gives status F and FAULT.
- Undefined: no counter exists and TIMEOUT_CYCLES is unused.

## Structure
- Shared package `hsi_pkg` holds:
  - OP_CROSS/OP_DOT;
  - ERR_NONE/OP/INPUT_FIFO_EMPTY/OUTPUT_FIFO_FULL/BANDS/TIMEOUT;
  - the driver state enum.
- One sub-module, `hsi_skid_buffer`: a 2-entry valid/ready register slice, parameterised on width.

## Test plan
- **CROSS happy path:** CROSS, bands 3, N = 2 with pairs (1,2,3)×(4,5,6) and (1,0,0)×(0,1,0). Required: m_data (−3,6,−3) then (0,0,1), then done, status 0.
- **DOT happy path:** DOT, bands 3, (1,2,3)·(4,5,6). Required: m_data lane 0 = 32, upper lanes 0.
- **Config errors:** `go` with CROSS and bands 2 → done within 2 cycles, status 1, no wr_en ever asserted. `go` with bands 5 → status 4.
- **Backpressure:** N = 20 with m_ready held low for 100 cycles. Required: pushes stall at 15 outstanding, core error_code stays 0, all 20 results arrive in order.
- **Injected core fault:** force error_code = 3 mid-job. Required: status 3, done pulse, s_ready = 0 held, `go` ignored until reset.
- **Timeout (HSI_DRIVER_TIMEOUT_EN, TIMEOUT_CYCLES = 64):** hold out_empty high after a push. Required: status F after 64 cycles.
